// File: rtl/ex_stage.sv
// Execute stage: ALU evaluation on decoded operands, two-entry (head + skid) output buffer,
// and forwarding lookup into the held entries for decode.

module alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [5:0] {
    OP_ADD  = 6'h10,
    OP_SUB  = 6'h11,
    OP_AND  = 6'h12,
    OP_OR   = 6'h13,
    OP_XOR  = 6'h14,
    OP_SLL  = 6'h15,
    OP_SRL  = 6'h16,
    OP_SRA  = 6'h17,
    OP_SLT  = 6'h18,
    OP_SLTU = 6'h19,
    OP_PASS = 6'h1a
  } alu_op_e;

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b[SHW-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = XLEN'($signed(a) >>> shamt);
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

endmodule

module ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [5:0]      id_alu_op_i,
  input  logic [XLEN-1:0] id_src_a_i,
  input  logic [XLEN-1:0] id_src_b_i,
  input  logic [RD_W-1:0] id_rd_i,
  input  logic            id_rf_we_i,
  input  logic [XLEN-1:0] id_pc_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_result_o,
  output logic [RD_W-1:0] mem_rd_o,
  output logic            mem_rf_we_o,
  output logic [XLEN-1:0] mem_pc_o,
  input  logic [RD_W-1:0] fwd_rs1_i,
  input  logic [RD_W-1:0] fwd_rs2_i,
  output logic            fwd_rs1_hit_o,
  output logic [XLEN-1:0] fwd_rs1_data_o,
  output logic            fwd_rs2_hit_o,
  output logic [XLEN-1:0] fwd_rs2_data_o
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd;
    logic            rf_we;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          head;
  entry_t          skid;
  entry_t          new_entry;
  logic            head_v;
  logic            skid_v;
  logic [XLEN-1:0] alu_result;
  logic            accept;
  logic            drain;

  alu #(.XLEN(XLEN)) u_alu (
    .op     (id_alu_op_i),
    .a      (id_src_a_i),
    .b      (id_src_b_i),
    .result (alu_result)
  );

  assign new_entry = '{result: alu_result, rd: id_rd_i, rf_we: id_rf_we_i, pc: id_pc_i};

  // Ready depends only on skid occupancy, so mem_ready_i never reaches id_ready_o combinationally.
  assign id_ready_o = !skid_v;
  assign accept     = id_valid_i && id_ready_o;
  assign drain      = head_v && mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= '0;
      skid   <= '0;
    end else if (flush_i) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!head_v || drain) begin
      if (skid_v) begin
        head   <= skid;
        head_v <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        head   <= new_entry;
        head_v <= 1'b1;
      end else begin
        head_v <= 1'b0;
      end
    end else if (accept) begin
      skid   <= new_entry;
      skid_v <= 1'b1;
    end
  end

  assign mem_valid_o  = head_v;
  assign mem_result_o = head.result;
  assign mem_rd_o     = head.rd;
  assign mem_rf_we_o  = head.rf_we;
  assign mem_pc_o     = head.pc;

  // Skid holds the younger entry, so it is checked first.
  function automatic logic [XLEN:0] fwd_lookup(input logic [RD_W-1:0] rs);
    logic [XLEN:0] r;
    r = '0;
    if (rs != '0) begin
      if (skid_v && skid.rf_we && (skid.rd == rs)) begin
        r = {1'b1, skid.result};
      end else if (head_v && head.rf_we && (head.rd == rs)) begin
        r = {1'b1, head.result};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_rs1_hit_o, fwd_rs1_data_o} = fwd_lookup(fwd_rs1_i);
    {fwd_rs2_hit_o, fwd_rs2_data_o} = fwd_lookup(fwd_rs2_i);
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: driver pushes expected entries into a scoreboard queue on acceptance,
// a negedge monitor compares outputs, occupancy and forwarding against that queue.

module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [5:0]  id_alu_op_i;
  logic [31:0] id_src_a_i;
  logic [31:0] id_src_b_i;
  logic [4:0]  id_rd_i;
  logic        id_rf_we_i;
  logic [31:0] id_pc_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_result_o;
  logic [4:0]  mem_rd_o;
  logic        mem_rf_we_o;
  logic [31:0] mem_pc_o;
  logic [4:0]  fwd_rs1_i;
  logic [4:0]  fwd_rs2_i;
  logic        fwd_rs1_hit_o;
  logic [31:0] fwd_rs1_data_o;
  logic        fwd_rs2_hit_o;
  logic [31:0] fwd_rs2_data_o;

  ex_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .id_valid_i     (id_valid_i),
    .id_ready_o     (id_ready_o),
    .id_alu_op_i    (id_alu_op_i),
    .id_src_a_i     (id_src_a_i),
    .id_src_b_i     (id_src_b_i),
    .id_rd_i        (id_rd_i),
    .id_rf_we_i     (id_rf_we_i),
    .id_pc_i        (id_pc_i),
    .mem_valid_o    (mem_valid_o),
    .mem_ready_i    (mem_ready_i),
    .mem_result_o   (mem_result_o),
    .mem_rd_o       (mem_rd_o),
    .mem_rf_we_o    (mem_rf_we_o),
    .mem_pc_o       (mem_pc_o),
    .fwd_rs1_i      (fwd_rs1_i),
    .fwd_rs2_i      (fwd_rs2_i),
    .fwd_rs1_hit_o  (fwd_rs1_hit_o),
    .fwd_rs1_data_o (fwd_rs1_data_o),
    .fwd_rs2_hit_o  (fwd_rs2_hit_o),
    .fwd_rs2_data_o (fwd_rs2_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   rand_fwd = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'h10: return a + b;
      6'h11: return a - b;
      6'h12: return a & b;
      6'h13: return a | b;
      6'h14: return a ^ b;
      6'h15: return a << b[4:0];
      6'h16: return a >> b[4:0];
      6'h17: return $signed(a) >>> b[4:0];
      6'h18: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h19: return (a < b) ? 32'd1 : 32'd0;
      6'h1a: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Youngest held entry that writes rs wins; register 0 never forwards.
  function automatic logic [32:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 33'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].we && exp_q[i].rd == rs) return {1'b1, exp_q[i].result};
    return 33'd0;
  endfunction

  always @(negedge clk_i) begin : monitor
    logic [32:0] f1, f2;
    if (mon_en) begin
      chk("mem_valid", mem_valid_o, exp_q.size() > 0);
      chk("id_ready", id_ready_o, exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        chk("mem_result", mem_result_o, exp_q[0].result);
        chk("mem_rd", mem_rd_o, exp_q[0].rd);
        chk("mem_rf_we", mem_rf_we_o, exp_q[0].we);
        chk("mem_pc", mem_pc_o, exp_q[0].pc);
      end
      f1 = ref_fwd(fwd_rs1_i);
      f2 = ref_fwd(fwd_rs2_i);
      chk("fwd1_hit", fwd_rs1_hit_o, f1[32]);
      chk("fwd1_data", fwd_rs1_data_o, f1[31:0]);
      chk("fwd2_hit", fwd_rs2_hit_o, f2[32]);
      chk("fwd2_data", fwd_rs2_data_o, f2[31:0]);
      if (mem_valid_o && mem_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // One clock: decide acceptance from the handshake seen mid-cycle, update the scoreboard at the edge.
  task automatic step();
    exp_t e;
    bit   acc, fl;
    @(negedge clk_i);
    acc = id_valid_i && id_ready_o && !flush_i;
    fl  = flush_i;
    e.result = ref_alu(id_alu_op_i, id_src_a_i, id_src_b_i);
    e.rd     = id_rd_i;
    e.we     = id_rf_we_i;
    e.pc     = id_pc_i;
    @(posedge clk_i);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    last_acc = acc;
    #1;
    if (rand_fwd) begin
      fwd_rs1_i = 5'($urandom_range(0, 7));
      fwd_rs2_i = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic [31:0] pc);
    id_alu_op_i = op;
    id_src_a_i  = a;
    id_src_b_i  = b;
    id_rd_i     = rd;
    id_rf_we_i  = we;
    id_pc_i     = pc;
  endtask

  task automatic send(output int cycles);
    id_valid_i = 1'b1;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!last_acc && cycles < 50);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    id_valid_i = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    mem_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_all", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, mem_valid_o, 0);
    chk({tag, "_ready"}, id_ready_o, 1);
    chk({tag, "_result"}, mem_result_o, 0);
    chk({tag, "_rd"}, mem_rd_o, 0);
    chk({tag, "_we"}, mem_rf_we_o, 0);
    chk({tag, "_pc"}, mem_pc_o, 0);
    chk({tag, "_fwd"}, {fwd_rs1_hit_o, fwd_rs1_data_o, fwd_rs2_hit_o, fwd_rs2_data_o}, 0);
  endtask

  logic [5:0] ops [11] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15,
                           6'h16, 6'h17, 6'h18, 6'h19, 6'h1a};

  initial begin
    int c;
    rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0; mem_ready_i = 1'b0;
    fwd_rs1_i = 5'd3; fwd_rs2_i = 5'd5;
    set_in(6'h10, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // Single add
    mem_ready_i = 1'b1;
    set_in(6'h10, 32'd5, 32'd7, 5'd3, 1'b1, 32'h8000_0000);
    send(c);
    chk("t1_latency", c, 1);
    chk("t1_valid", mem_valid_o, 1);
    chk("t1_result", mem_result_o, 12);
    chk("t1_rd", mem_rd_o, 3);
    chk("t1_pc", mem_pc_o, 32'h8000_0000);
    chk("t1_ready", id_ready_o, 1);
    step();

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      set_in(6'h10, 32'(i), 32'd100, 5'(i + 1), 1'b1, 32'h100 + 32'(4 * i));
      send(c);
      chk("t2_cycles", c, 1);
      chk("t2_valid", mem_valid_o, 1);
      chk("t2_ready", id_ready_o, 1);
    end
    step();

    // Stall: A in head, B in skid, C held upstream
    mem_ready_i = 1'b0;
    set_in(6'h11, 32'd50, 32'd8, 5'd7, 1'b1, 32'h200);
    send(c);
    set_in(6'h12, 32'hff00, 32'h0ff0, 5'd8, 1'b1, 32'h204);
    send(c);
    chk("t3_ready_low", id_ready_o, 0);
    set_in(6'h13, 32'h1, 32'h2, 5'd9, 1'b0, 32'h208);
    id_valid_i = 1'b1;
    repeat (3) step();
    chk("t3_c_held", last_acc, 0);
    chk("t3_a_stable", mem_pc_o, 32'h200);
    mem_ready_i = 1'b1;
    step();
    chk("t3_c_not_taken", last_acc, 0);
    chk("t3_b_in_head", mem_pc_o, 32'h204);
    chk("t3_ready_back", id_ready_o, 1);
    step();
    chk("t3_c_taken", last_acc, 1);
    id_valid_i = 1'b0;
    step();
    step();

    // Forwarding priority, rf_we=0, then flush with a concurrent offer
    rand_fwd = 1'b0;
    drain_all();
    mem_ready_i = 1'b0;
    set_in(6'h1a, 32'd0, 32'h11, 5'd5, 1'b1, 32'h300);
    send(c);
    set_in(6'h1a, 32'd0, 32'h22, 5'd5, 1'b1, 32'h304);
    send(c);
    fwd_rs1_i = 5'd5; fwd_rs2_i = 5'd0;
    #1;
    chk("t4_rs1_hit", fwd_rs1_hit_o, 1);
    chk("t4_rs1_data", fwd_rs1_data_o, 32'h22);
    chk("t4_rs2_hit", fwd_rs2_hit_o, 0);
    chk("t4_rs2_data", fwd_rs2_data_o, 0);
    drain_all();
    mem_ready_i = 1'b0;
    set_in(6'h1a, 32'd0, 32'h33, 5'd5, 1'b0, 32'h308);
    send(c);
    set_in(6'h1a, 32'd0, 32'h44, 5'd6, 1'b1, 32'h30c);
    send(c);
    fwd_rs2_i = 5'd6;
    #1;
    chk("t4_nowe_miss", fwd_rs1_hit_o, 0);
    chk("t4_nowe_data", fwd_rs1_data_o, 0);
    chk("t4_rs2_skid", fwd_rs2_data_o, 32'h44);
    set_in(6'h10, 32'd1, 32'd1, 5'd6, 1'b1, 32'h310);
    id_valid_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    id_valid_i = 1'b0;
    chk("t5_valid", mem_valid_o, 0);
    chk("t5_ready", id_ready_o, 1);
    chk("t5_fwd", {fwd_rs1_hit_o, fwd_rs2_hit_o}, 0);
    step();
    chk("t5_discarded", mem_valid_o, 0);

    // Asynchronous reset mid-stall
    set_in(6'h10, 32'd9, 32'd9, 5'd4, 1'b1, 32'h400);
    send(c);
    set_in(6'h10, 32'd3, 32'd4, 5'd2, 1'b1, 32'h404);
    send(c);
    chk("t6_full", id_ready_o, 0);
    fwd_rs1_i = 5'd4; fwd_rs2_i = 5'd2;
    #2;
    mon_en = 1'b0;
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // Randomized traffic
    rand_fwd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)],
             $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      id_valid_i  = ($urandom_range(0, 9) < 7);
      mem_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush_i = 1'b0;
    id_valid_i = 1'b0;
    drain_all();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage between instruction decode and memory access. Accepts decoded operands over a valid/ready handshake, evaluates them through the existing `alu` module, and registers the result with its destination metadata. A two-entry skid buffer decouples back-pressure. Bypass lookup ports let decode forward in-flight results.

## Interface
- XLEN, 32, datapath width; fixed by `alu`
- RD_W, 5, register-index width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- flush_i  in  1  synchronous squash of all held entries
- id_valid_i  in  1  decode presents an instruction
- id_ready_o  out  1  stage can accept this cycle
- id_alu_op_i  in  6  ALU operation code, passed unchanged to `alu`
- id_src_a_i / id_src_b_i  in  XLEN  ALU operands
- id_rd_i  in  RD_W  destination register
- id_rf_we_i  in  1  entry writes the register file
- id_pc_i  in  XLEN  instruction PC, carried through
- mem_valid_o  out  1  head entry valid
- mem_ready_i  in  1  downstream accepts head
- mem_result_o  out  XLEN  head ALU result
- mem_rd_o  out  RD_W; mem_rf_we_o  out  1; mem_pc_o  out  XLEN  head metadata
- fwd_rs1_i / fwd_rs2_i  in  RD_W  decode source-register queries
- fwd_rs1_hit_o / fwd_rs2_hit_o  out  1  query matches a held entry
- fwd_rs1_data_o / fwd_rs2_data_o  out  XLEN  forwarded value; 0 on miss

## Operation
- ALU is combinational on the id_* inputs. Its result is captured together with rd, rf_we, and pc as one entry.
- Storage: head register, which drives the mem_* outputs, and skid register. Valid bits are head_v and skid_v.
- accept = id_valid_i & id_ready_o; drain = mem_valid_o & mem_ready_i.
- id_ready_o = !skid_v. It is registered state, with no combinational path from mem_ready_i.
- Update priority:
  1. flush_i: head_v<=0, skid_v<=0. Any accept in the same cycle is discarded.
  2. Head empty or draining, skid_v=1: head<=skid, skid_v<=0. No accept is possible, since id_ready_o=0.
  3. Head empty or draining, skid_v=0: if accept, head<=new and head_v<=1; else head_v<=0.
  4. Head full and not draining: if accept, skid<=new and skid_v<=1.
- Ordering: head is always older than skid. Entries leave strictly in acceptance order.
- Entries with rf_we=0 (stores, branches) still flow normally.
- Forwarding, evaluated independently per port from registered state only:
  - Hit on skid if skid_v & skid.rf_we & skid.rd==rs & rs!=0. This is the youngest and wins.
  - Else hit on head under the same condition.
  - Else miss with data 0.
  - rs==0 never hits.
- Data registers load only when written. Values are otherwise held, and not cleared by flush.

## Timing
- Reset values:
  - mem_valid_o=0, id_ready_o=1.
  - mem_result_o=0, mem_rd_o=0, mem_rf_we_o=0, mem_pc_o=0.
  - All fwd_*_hit_o=0 and fwd_*_data_o=0.
  - skid contents 0.
- Reset mid-transfer drops both entries immediately, asynchronously.
- Latency: accept in cycle N gives mem_valid_o=1 in cycle N+1 when the head is empty or draining.
- Throughput is 1 entry/cycle while mem_ready_i=1.
- Stall: while mem_valid_o & !mem_ready_i, all mem_* outputs stay stable. One extra entry is absorbed into skid; id_ready_o falls the following cycle.
- Recovery: the first drain moves skid into head. id_ready_o rises the cycle after the drain.
- Flush: cycle after flush_i, mem_valid_o=0, id_ready_o=1, and forwarding misses.
- Simultaneous drain and accept with skid empty: new entry replaces head, with no bubble.

## Test plan
- Reset release, then add (alu_op 6'h10), a=5, b=7, rd=3, we=1, pc=0x80000000, with mem_ready_i=1. Required: mem_valid_o=1 next cycle with result=12, rd=3, pc=0x80000000. id_ready_o stays 1.
- Stream 4 back-to-back adds with mem_ready_i=1. Required: 4 consecutive valid outputs in order, no bubbles, id_ready_o constantly 1.
- Hold mem_ready_i=0 and offer 3 entries A, B, C.
  - A sits in head, B goes to skid, id_ready_o=0 from the next cycle, C is held upstream.
  - Raise mem_ready_i: outputs A, B, C in order; id_ready_o returns to 1 the cycle after A drains.
- Head rd=5 (value 0x11) and skid rd=5 (value 0x22), both with we=1. Query rs1=5, rs2=0. Required: rs1 hit with data 0x22, rs2 miss with data 0. A same-rd entry with we=0 gives no hit.
- Both entries full, then assert flush_i together with id_valid_i. Required: next cycle mem_valid_o=0, id_ready_o=1, the flushed-cycle input is discarded, and forwarding misses.
- Assert rst_i asynchronously mid-stall with both entries full. Required: mem_valid_o=0 and id_ready_o=1 without waiting for a clock edge, and all outputs at reset values.
